hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage MIPS32 core.
- Drives the 2-bit HzCtrl input of every pipeline register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Encoding: 00 normal, 01 flush, 10 stall.
- Resolves four hazard sources with fixed priority: memory wait, taken branch, load-use and jump.
- Runs a small FSM for multi-cycle data-memory waits, including a timeout.
- Keeps stall and flush performance counters.

Parameters:
- MEM_WAIT_MAX, 15, maximum value of the wait counter before the timeout is declared.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (rst==0 resets).
- ID_RsAddr  in  5  rs field of the instruction in ID.
- ID_RtAddr  in  5  rt field of the instruction in ID.
- ID_UseRs  in  1  the ID instruction reads rs.
- ID_UseRt  in  1  the ID instruction reads rt.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_RtAddr  in  5  destination register of the load in EX.
- ID_Jump  in  1  a j/jal/jr/jalr is decoded in ID.
- EX_BranchTaken  in  1  a branch resolved as taken in EX.
- MemReq  in  1  the MEM stage is accessing data memory or a peripheral.
- MemReady  in  1  the data access completes this cycle.
- PC_HzCtrl  out  2  PC control; only 00 (update) or 10 (hold) is driven.
- IF_ID_HzCtrl  out  2  IF/ID register control.
- ID_EX_HzCtrl  out  2  ID/EX register control.
- EX_MEM_HzCtrl  out  2  EX/MEM register control.
- MEM_WB_HzCtrl  out  2  MEM/WB register control.
- StallCnt  out  CNT_W  number of cycles with PC held.
- FlushCnt  out  CNT_W  number of cycles with IF/ID flushed.
- MemTimeout  out  1  sticky memory-timeout error flag.

Behaviour:
- Reset (rst==0, async):
  - FSM goes to RUN; wait_cnt=0.
  - StallCnt=0, FlushCnt=0, MemTimeout=0.
  - All HzCtrl outputs = 00 while reset is held.
- FSM states RUN, MEM_WAIT, MEM_ERR:
  - RUN: if MemReq && !MemReady, set wait_cnt<=1 and go to MEM_WAIT; otherwise stay.
  - MEM_WAIT:
    - MemReady=1: wait_cnt<=0, go to RUN.
    - Else if wait_cnt==MEM_WAIT_MAX: go to MEM_ERR.
    - Else wait_cnt<=wait_cnt+1.
  - MEM_ERR: terminal until reset. MemTimeout=1 (registered, equal to state==MEM_ERR). MemReq and MemReady are ignored.
- MemTimeout rises on the edge ending the (MEM_WAIT_MAX+1)-th consecutive not-ready cycle.
- HzCtrl outputs are combinational from state and inputs, so they act in the same cycle. Priority is highest first; unlisted outputs are 00.
  - P1, memory wait: (RUN && MemReq && !MemReady) or (MEM_WAIT && !MemReady) or MEM_ERR.
    - PC, IF_ID, ID_EX and EX_MEM = 10.
    - MEM_WB = 01.
  - P2, taken branch: EX_BranchTaken.
    - IF_ID = 01, ID_EX = 01.
    - PC = 00 (target is loaded).
  - P3, load-use: ID_EX_MemRead && ID_EX_RtAddr!=0 && ((ID_UseRs && ID_RsAddr==ID_EX_RtAddr) || (ID_UseRt && ID_RtAddr==ID_EX_RtAddr)).
    - PC = 10, IF_ID = 10.
    - ID_EX = 01 (bubble).
  - P4, jump: ID_Jump.
    - IF_ID = 01, PC = 00.
  - P5: all outputs 00.
- A branch or load-use masked by P1 is not lost. EX and ID contents are frozen, so the condition reasserts when the wait ends.
- MEM_WAIT with MemReady=1: the access completes and P2–P5 are evaluated in the same cycle.
- A single-cycle access (MemReq && MemReady in RUN) causes no stall.
- Load-use and jump together in ID: load-use wins. The jump is re-evaluated next cycle.
- StallCnt increments on each edge where PC_HzCtrl==10. FlushCnt increments on each edge where IF_ID_HzCtrl==01.
- Both counters saturate at all-ones.
- Reset asserted mid-wait or in MEM_ERR immediately returns to RUN with counters cleared.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RtAddr=8, ID_RsAddr=8, ID_UseRs=1 for 1 cycle.
  - Expect PC=10, IF_ID=10, ID_EX=01; StallCnt goes 0→1.
  - Repeat with ID_EX_RtAddr=0: expect all outputs 00.
- Branch beats load-use: EX_BranchTaken=1 with the load-use condition true.
  - Expect IF_ID=01, ID_EX=01, PC=00; FlushCnt +1, StallCnt unchanged.
- Memory wait: MemReq=1, MemReady=0 for 3 cycles, then 1.
  - Expect 3 cycles of PC/IF_ID/ID_EX/EX_MEM=10 with MEM_WB=01, then all 00.
  - StallCnt=3; FSM back in RUN.
- Wait ends with a branch: MEM_WAIT with MemReady=1 and EX_BranchTaken=1 in the same cycle.
  - Expect IF_ID=01, ID_EX=01, EX_MEM=00.
- Timeout (MEM_WAIT_MAX=15): MemReq=1, MemReady held 0.
  - MemTimeout=1 after 16 cycles; all stages stalled indefinitely.
  - Later MemReady=1 has no effect.
  - Driving rst=0 asynchronously clears MemTimeout and the counters.
- Counter saturation (CNT_W=4): 20 consecutive stall cycles → StallCnt=15 and holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS32 core
//   in : clk, rst (async, active-low), ID_RsAddr/ID_RtAddr/ID_UseRs/ID_UseRt (ID operands),
//        ID_EX_MemRead/ID_EX_RtAddr (load in EX), ID_Jump, EX_BranchTaken, MemReq, MemReady
//   out: PC/IF_ID/ID_EX/EX_MEM/MEM_WB_HzCtrl (00 normal, 01 flush, 10 stall),
//        StallCnt, FlushCnt (saturating), MemTimeout (sticky until reset)
module hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_RsAddr,
  input  logic [4:0]       ID_RtAddr,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RtAddr,
  input  logic             ID_Jump,
  input  logic             EX_BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic [1:0]       PC_HzCtrl,
  output logic [1:0]       IF_ID_HzCtrl,
  output logic [1:0]       ID_EX_HzCtrl,
  output logic [1:0]       EX_MEM_HzCtrl,
  output logic [1:0]       MEM_WB_HzCtrl,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic             MemTimeout
);
  localparam int WW = MEM_WAIT_MAX < 1 ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [1:0] NORM = 2'b00;
  localparam logic [1:0] FLUSH = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;
  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic mem_busy, load_use;
  logic [9:0] hz;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
    end
  always_comb begin
    state_nx = state;
    wait_nx = wait_cnt;
    if (state == RUN && MemReq && !MemReady) begin
      state_nx = MEM_WAIT;
      wait_nx = WW'(1);
    end else if (state == MEM_WAIT) begin
      if (MemReady) begin
        state_nx = RUN;
        wait_nx = '0;
      end else if (wait_cnt == WW'(MEM_WAIT_MAX)) state_nx = MEM_ERR;
      else wait_nx = wait_cnt + 1'b1;
    end
  end
  // a wait that completes this cycle releases the pipeline immediately, so lower priorities apply
  assign mem_busy = (state == RUN && MemReq && !MemReady) || (state == MEM_WAIT && !MemReady) ||
                    state == MEM_ERR;
  assign load_use = ID_EX_MemRead && ID_EX_RtAddr != 5'd0 &&
                    ((ID_UseRs && ID_RsAddr == ID_EX_RtAddr) || (ID_UseRt && ID_RtAddr == ID_EX_RtAddr));
  // order: PC, IF/ID, ID/EX, EX/MEM, MEM/WB; everything idles while reset is held
  always_comb begin
    hz = !rst ? '0 :
         mem_busy ? {HOLD, HOLD, HOLD, HOLD, FLUSH} :
         EX_BranchTaken ? {NORM, FLUSH, FLUSH, NORM, NORM} :
         load_use ? {HOLD, HOLD, FLUSH, NORM, NORM} :
         ID_Jump ? {NORM, FLUSH, NORM, NORM, NORM} : '0;
  end
  assign {PC_HzCtrl, IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl, MEM_WB_HzCtrl} = hz;
  assign MemTimeout = state == MEM_ERR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (PC_HzCtrl == HOLD && !(&StallCnt)) StallCnt <= StallCnt + 1'b1;
      if (IF_ID_HzCtrl == FLUSH && !(&FlushCnt)) FlushCnt <= FlushCnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int MWM = 15;
  localparam logic [9:0] STALL = 10'b10_10_10_10_01;
  localparam logic [9:0] BR = 10'b00_01_01_00_00;
  localparam logic [9:0] LU = 10'b10_10_01_00_00;
  localparam logic [9:0] JMP = 10'b00_01_00_00_00;
  logic clk = 0, rst;
  logic [4:0] ID_RsAddr, ID_RtAddr, ID_EX_RtAddr;
  logic ID_UseRs, ID_UseRt, ID_EX_MemRead, ID_Jump, EX_BranchTaken, MemReq, MemReady;
  logic [1:0] pc, ifid, idex, exmem, memwb, pc2, ifid2, idex2, exmem2, memwb2;
  logic [31:0] scnt_d, fcnt_d;
  logic [3:0] scnt4, fcnt4;
  logic to, to2;
  logic [9:0] hz, hz2;
  int n_chk = 0, n_fail = 0;
  int wait_run;
  bit err;
  longint scnt, fcnt;
  always #5 clk = ~clk;
  assign hz = {pc, ifid, idex, exmem, memwb};
  assign hz2 = {pc2, ifid2, idex2, exmem2, memwb2};
  hazard_ctrl #(.MEM_WAIT_MAX(MWM), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RtAddr(ID_EX_RtAddr),
    .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PC_HzCtrl(pc), .IF_ID_HzCtrl(ifid), .ID_EX_HzCtrl(idex), .EX_MEM_HzCtrl(exmem),
    .MEM_WB_HzCtrl(memwb), .StallCnt(scnt_d), .FlushCnt(fcnt_d), .MemTimeout(to));
  hazard_ctrl #(.MEM_WAIT_MAX(MWM), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RtAddr(ID_EX_RtAddr),
    .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PC_HzCtrl(pc2), .IF_ID_HzCtrl(ifid2), .ID_EX_HzCtrl(idex2), .EX_MEM_HzCtrl(exmem2),
    .MEM_WB_HzCtrl(memwb2), .StallCnt(scnt4), .FlushCnt(fcnt4), .MemTimeout(to2));

  function automatic bit mem_busy();
    return err || (!MemReady && (wait_run > 0 || MemReq));
  endfunction

  function automatic logic [9:0] exp_hz();
    bit lu;
    lu = ID_EX_MemRead && ID_EX_RtAddr != 0 &&
         ((ID_UseRs && ID_RsAddr == ID_EX_RtAddr) || (ID_UseRt && ID_RtAddr == ID_EX_RtAddr));
    if (!rst) return '0;
    if (mem_busy()) return STALL;
    if (EX_BranchTaken) return BR;
    if (lu) return LU;
    if (ID_Jump) return JMP;
    return '0;
  endfunction

  function automatic logic [3:0] sat4(longint v);
    logic [3:0] r;
    r = v > 15 ? 4'd15 : 4'(v);
    return r;
  endfunction

  task automatic clear_in();
    {ID_RsAddr, ID_RtAddr, ID_EX_RtAddr} = '0;
    {ID_UseRs, ID_UseRt, ID_EX_MemRead, ID_Jump, EX_BranchTaken, MemReq, MemReady} = '0;
  endtask

  task automatic model_reset();
    wait_run = 0;
    err = 0;
    scnt = 0;
    fcnt = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    clear_in();
    model_reset();
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic tick();
    logic [9:0] e;
    bit m;
    e = exp_hz();
    m = mem_busy();
    @(posedge clk);
    if (e[9:8] == 2'b10) scnt++;
    if (e[7:6] == 2'b01) fcnt++;
    if (!err) begin
      if (m) begin
        wait_run++;
        if (wait_run > MWM) err = 1;
      end else wait_run = 0;
    end
    #1;
  endtask

  task automatic set_load_use();
    ID_EX_MemRead = 1;
    ID_EX_RtAddr = 8;
    ID_RsAddr = 8;
    ID_UseRs = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_in();
    #1 rst = 0;
    MemReq = 1;
    EX_BranchTaken = 1;
    ID_Jump = 1;
    #2;
    n_chk++;
    if (hz !== 10'b0 || hz2 !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_hz: got %b/%b want 0", hz, hz2);
    end
    n_chk++;
    if (scnt_d !== 0 || fcnt_d !== 0 || to !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got stall=%0d flush=%0d to=%b want 0 0 0", scnt_d, fcnt_d, to);
    end
    clear_in();
    model_reset();
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use();
    #2;
    n_chk++;
    if (hz !== LU) begin
      n_fail++;
      $display("FAIL load_use_rs: got %b want %b", hz, LU);
    end
    tick();
    n_chk++;
    if (scnt_d !== 1) begin
      n_fail++;
      $display("FAIL load_use_cnt: got %0d want 1", scnt_d);
    end
    ID_EX_RtAddr = 0;
    ID_RsAddr = 0;
    #2;
    n_chk++;
    if (hz !== 10'b0) begin
      n_fail++;
      $display("FAIL load_use_r0: got %b want 0", hz);
    end
    tick();
    ID_EX_RtAddr = 9;
    ID_RsAddr = 9;
    ID_UseRs = 0;
    ID_UseRt = 1;
    ID_RtAddr = 9;
    #2;
    n_chk++;
    if (hz !== LU) begin
      n_fail++;
      $display("FAIL load_use_rt: got %b want %b", hz, LU);
    end
    tick();
    ID_UseRt = 0;
    #2;
    n_chk++;
    if (hz !== 10'b0) begin
      n_fail++;
      $display("FAIL load_use_unused: got %b want 0", hz);
    end
    tick();
    n_chk++;
    if (scnt_d !== 2 || scnt_d !== scnt[31:0]) begin
      n_fail++;
      $display("FAIL load_use_total: got %0d want 2", scnt_d);
    end
    clear_in();
  endtask

  task automatic test_priority();
    apply_reset();
    set_load_use();
    EX_BranchTaken = 1;
    #2;
    n_chk++;
    if (hz !== BR) begin
      n_fail++;
      $display("FAIL branch_over_lu: got %b want %b", hz, BR);
    end
    tick();
    n_chk++;
    if (fcnt_d !== 1 || scnt_d !== 0) begin
      n_fail++;
      $display("FAIL branch_cnt: got stall=%0d flush=%0d want 0 1", scnt_d, fcnt_d);
    end
    EX_BranchTaken = 0;
    ID_Jump = 1;
    #2;
    n_chk++;
    if (hz !== LU) begin
      n_fail++;
      $display("FAIL lu_over_jump: got %b want %b", hz, LU);
    end
    tick();
    ID_EX_MemRead = 0;
    #2;
    n_chk++;
    if (hz !== JMP) begin
      n_fail++;
      $display("FAIL jump: got %b want %b", hz, JMP);
    end
    tick();
    n_chk++;
    if (fcnt_d !== 2 || scnt_d !== 1) begin
      n_fail++;
      $display("FAIL jump_cnt: got stall=%0d flush=%0d want 1 2", scnt_d, fcnt_d);
    end
    clear_in();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    MemReq = 1;
    MemReady = 1;
    #2;
    n_chk++;
    if (hz !== 10'b0) begin
      n_fail++;
      $display("FAIL single_cycle_access: got %b want 0", hz);
    end
    tick();
    MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_chk++;
      if (hz !== STALL) begin
        n_fail++;
        $display("FAIL mem_wait_%0d: got %b want %b", i, hz, STALL);
      end
      tick();
    end
    MemReady = 1;
    #2;
    n_chk++;
    if (hz !== 10'b0) begin
      n_fail++;
      $display("FAIL mem_ready: got %b want 0", hz);
    end
    tick();
    n_chk++;
    if (scnt_d !== 3) begin
      n_fail++;
      $display("FAIL mem_wait_cnt: got %0d want 3", scnt_d);
    end
    MemReq = 0;
    MemReady = 0;
    #2;
    n_chk++;
    if (hz !== 10'b0) begin
      n_fail++;
      $display("FAIL back_in_run: got %b want 0", hz);
    end
    tick();
  endtask

  task automatic test_wait_branch();
    apply_reset();
    MemReq = 1;
    #2;
    tick();
    MemReady = 1;
    EX_BranchTaken = 1;
    #2;
    n_chk++;
    if (hz !== BR) begin
      n_fail++;
      $display("FAIL wait_end_branch: got %b want %b", hz, BR);
    end
    tick();
    clear_in();
  endtask

  task automatic test_timeout();
    apply_reset();
    MemReq = 1;
    for (int i = 0; i < MWM + 1; i++) begin
      #2;
      n_chk++;
      if (to !== 0 || hz !== STALL) begin
        n_fail++;
        $display("FAIL timeout_pre_%0d: got to=%b hz=%b want 0 %b", i, to, hz, STALL);
      end
      tick();
    end
    MemReq = 0;
    MemReady = 1;
    EX_BranchTaken = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_chk++;
      if (to !== 1 || hz !== STALL) begin
        n_fail++;
        $display("FAIL timeout_hold_%0d: got to=%b hz=%b want 1 %b", i, to, hz, STALL);
      end
      tick();
    end
    #2 rst = 0;
    #1;
    n_chk++;
    if (to !== 0 || scnt_d !== 0 || fcnt_d !== 0 || hz !== 10'b0) begin
      n_fail++;
      $display("FAIL timeout_reset: got to=%b stall=%0d flush=%0d hz=%b want 0 0 0 0",
               to, scnt_d, fcnt_d, hz);
    end
    model_reset();
    clear_in();
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic test_saturation();
    apply_reset();
    set_load_use();
    for (int i = 1; i <= 20; i++) begin
      #2;
      tick();
      n_chk++;
      if (scnt4 !== sat4(i) || scnt_d !== 32'(i)) begin
        n_fail++;
        $display("FAIL sat_%0d: got %0d/%0d want %0d/%0d", i, scnt4, scnt_d, sat4(i), i);
      end
    end
    clear_in();
  endtask

  task automatic test_random();
    logic [9:0] e;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      ID_RsAddr = 5'($urandom_range(0, 3));
      ID_RtAddr = 5'($urandom_range(0, 3));
      ID_EX_RtAddr = 5'($urandom_range(0, 3));
      ID_UseRs = 1'($urandom);
      ID_UseRt = 1'($urandom);
      ID_EX_MemRead = 1'($urandom);
      ID_Jump = $urandom_range(0, 3) == 0;
      EX_BranchTaken = $urandom_range(0, 4) == 0;
      MemReq = $urandom_range(0, 2) == 0;
      MemReady = $urandom_range(0, 3) != 0;
      #2;
      e = exp_hz();
      n_chk++;
      if (hz !== e || hz2 !== e || to !== err) begin
        n_fail++;
        $display("FAIL rand_hz_%0d: got %b/%b to=%b want %b to=%b", i, hz, hz2, to, e, err);
      end
      tick();
      n_chk++;
      if (scnt_d !== scnt[31:0] || fcnt_d !== fcnt[31:0] || scnt4 !== sat4(scnt) ||
          fcnt4 !== sat4(fcnt)) begin
        n_fail++;
        $display("FAIL rand_cnt_%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, scnt_d, fcnt_d,
                 scnt4, fcnt4, scnt, fcnt, sat4(scnt), sat4(fcnt));
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_wait_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
